jtag_tap_controller: RTL and testbench



---
 rtl/jtag_pkg.sv | 32 +++
 rtl/jtag_tap_controller_if.sv | 27 ++
 rtl/jtag_tap_fsm.sv | 59 +++++
 rtl/jtag_tap_controller.sv | 165 ++++++++++++++++
 tb/tb_jtag_tap_controller.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG TAP types: 16-state tap_state_t, instruction codes, IR width.
// JTAG_USERCODE_EN enables the optional USERCODE instruction (code 1000).
package jtag_pkg;

  localparam int IR_WIDTH_DEF = 4;

  localparam logic [3:0] INSTR_EXTEST         = 4'b0000;
  localparam logic [3:0] INSTR_IDCODE         = 4'b0001;
  localparam logic [3:0] INSTR_SAMPLE_PRELOAD = 4'b0010;
  localparam logic [3:0] INSTR_USERCODE       = 4'b1000;
  localparam logic [3:0] INSTR_BYPASS         = 4'b1111;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

endpackage

// File: rtl/jtag_tap_controller_if.sv
// Boundary-scan chain bundle between the TAP and the downstream BSR.
// master = TAP side, slave = BSR side.
interface jtag_tap_controller_if;

  logic bsr_tdo;
  logic bsr_capture;
  logic bsr_shift;
  logic bsr_update;
  logic extest;

  modport master (
    input  bsr_tdo,
    output bsr_capture,
    output bsr_shift,
    output bsr_update,
    output extest
  );

  modport slave (
    output bsr_tdo,
    input  bsr_capture,
    input  bsr_shift,
    input  bsr_update,
    input  extest
  );

endinterface

// File: rtl/jtag_tap_fsm.sv
// 1149.1 TAP state machine: state register, next-state logic and
// decoded capture/shift/update flags for the IR and DR paths.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr
);

  tap_state_t nxt;

  // State register, advanced on tck rising edge.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state <= TEST_LOGIC_RESET;
    else       state <= nxt;
  end

  // Next state from current state and tms.
  always_comb begin
    nxt = state;
    unique case (state)
      TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN : CAPTURE_DR;
      CAPTURE_DR:       nxt = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         nxt = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         nxt = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         nxt = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         nxt = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       nxt = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         nxt = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         nxt = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         nxt = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         nxt = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
    endcase
  end

  // Decoded per-state strobes.
  always_comb begin
    capture_ir = (state == CAPTURE_IR);
    shift_ir   = (state == SHIFT_IR);
    update_ir  = (state == UPDATE_IR);
    capture_dr = (state == CAPTURE_DR);
    shift_dr   = (state == SHIFT_DR);
    update_dr  = (state == UPDATE_DR);
  end

endmodule

// File: rtl/jtag_tap_controller.sv
// JTAG TAP front end: IR, BYPASS/IDCODE data registers, BSR strobes, tdo mux.
// Define JTAG_USERCODE_EN to add the USERCODE instruction and register.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH     = IR_WIDTH_DEF,
  parameter logic [31:0] IDCODE_VAL   = 32'h1000_0CFD
`ifdef JTAG_USERCODE_EN
  ,
  parameter logic [31:0] USERCODE_VAL = 32'h0000_0000
`endif
) (
  input  logic tck,
  input  logic trst,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_en,
  output logic tap_reset,
  jtag_tap_controller_if.master bsr
);

  localparam logic [IR_WIDTH-1:0] IR_EXT = IR_WIDTH'(INSTR_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_IDC = IR_WIDTH'(INSTR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_SMP = IR_WIDTH'(INSTR_SAMPLE_PRELOAD);
  localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(2'b01);
  localparam logic [31:0] IDC_CAP = IDCODE_VAL | 32'h1;

  tap_state_t state;
  logic capture_ir, shift_ir, update_ir;
  logic capture_dr, shift_dr, update_dr;

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .state      (state),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr)
  );

  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] instr;
  logic                bypass;
  logic [31:0]         idcode;

  logic sel_ext, sel_smp, sel_idc, sel_bsr, sel_usr;
  logic dr_lsb;

  assign tap_reset = (state == TEST_LOGIC_RESET);

  // IR shift register: capture 0..01, shift right with tdi into MSB.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_shift <= '0;
    end else if (capture_ir) begin
      ir_shift <= IR_CAP;
    end else if (shift_ir) begin
      ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
    end
  end

  // Instruction latches on falling edge of Update-IR; TLR forces IDCODE.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      instr <= IR_IDC;
    end else if (tap_reset) begin
      instr <= IR_IDC;
    end else if (update_ir) begin
      instr <= ir_shift;
    end
  end

  // Instruction decode; undefined codes fall through to BYPASS.
  always_comb begin
    sel_ext = 1'b0;
    sel_smp = 1'b0;
    sel_idc = 1'b0;
    sel_usr = 1'b0;
    unique case (1'b1)
      (instr == IR_EXT): sel_ext = 1'b1;
      (instr == IR_SMP): sel_smp = 1'b1;
      (instr == IR_IDC): sel_idc = 1'b1;
`ifdef JTAG_USERCODE_EN
      (instr == IR_WIDTH'(INSTR_USERCODE)): sel_usr = 1'b1;
`endif
      default: ;
    endcase
  end

  assign sel_bsr = sel_ext | sel_smp;

  // Bypass bit: capture 0, shift tdi.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      bypass <= 1'b0;
    end else if (!sel_bsr && !sel_idc && !sel_usr) begin
      if (capture_dr)    bypass <= 1'b0;
      else if (shift_dr) bypass <= tdi;
    end
  end

  // IDCODE register: capture device ID, shift right with tdi into bit 31.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      idcode <= '0;
    end else if (sel_idc) begin
      if (capture_dr)    idcode <= IDC_CAP;
      else if (shift_dr) idcode <= {tdi, idcode[31:1]};
    end
  end

`ifdef JTAG_USERCODE_EN
  logic [31:0] usercode;

  // USERCODE register: capture USERCODE_VAL, shift like IDCODE.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      usercode <= '0;
    end else if (sel_usr) begin
      if (capture_dr)    usercode <= USERCODE_VAL;
      else if (shift_dr) usercode <= {tdi, usercode[31:1]};
    end
  end
`endif

  // Serial return of the selected data register.
  always_comb begin
    dr_lsb = bypass;
    unique case (1'b1)
      sel_bsr: dr_lsb = bsr.bsr_tdo;
      sel_idc: dr_lsb = idcode[0];
`ifdef JTAG_USERCODE_EN
      sel_usr: dr_lsb = usercode[0];
`endif
      default: ;
    endcase
  end

  // tdo and tdo_en registered on the falling edge.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= shift_ir | shift_dr;
      if (shift_ir)      tdo <= ir_shift[0];
      else if (shift_dr) tdo <= dr_lsb;
      else               tdo <= 1'b0;
    end
  end

  // BSR strobes straight from state so trst drops them at once.
  always_comb begin
    bsr.bsr_capture = capture_dr & sel_bsr;
    bsr.bsr_shift   = shift_dr & sel_bsr;
    bsr.bsr_update  = update_dr & sel_bsr;
    bsr.extest      = sel_ext;
  end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller: reset, IDCODE, IR, BYPASS,
// EXTEST strobes and trst abort, checked with immediate assertions.
module tb_jtag_tap_controller;

  logic tck = 1'b0;
  logic trst, tms, tdi;
  logic tdo, tdo_en, tap_reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] d;

  jtag_tap_controller_if bsr ();

  jtag_tap_controller dut (
    .tck       (tck),
    .trst      (trst),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tdo_en    (tdo_en),
    .tap_reset (tap_reset),
    .bsr       (bsr)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic m, input logic i);
    tms = m;
    tdi = i;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  // From RTI: scan n DR bits (din LSB first), collect tdo, back to RTI.
  task automatic read_dr(input int n, input logic [31:0] din,
                         output logic [31:0] dout);
    dout = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    dout[0] = tdo;
    for (int i = 1; i < n; i++) begin
      step(1'b0, din[i-1]);
      dout[i] = tdo;
    end
    step(1'b1, din[n-1]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From RTI: load a 4-bit instruction, back to RTI.
  task automatic load_ir(input logic [3:0] code);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, code[i]);
    step(1'b1, code[3]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic chk_abort(input string tag);
    chk({tag, "_tap_reset"}, tap_reset, 1);
    chk({tag, "_tdo"}, tdo, 0);
    chk({tag, "_tdo_en"}, tdo_en, 0);
    chk({tag, "_extest"}, bsr.extest, 0);
    chk({tag, "_bsr_cap"}, bsr.bsr_capture, 0);
    chk({tag, "_bsr_shift"}, bsr.bsr_shift, 0);
    chk({tag, "_bsr_upd"}, bsr.bsr_update, 0);
  endtask

  initial begin
    trst = 1'b0;
    tms = 1'b1;
    tdi = 1'b0;
    bsr.bsr_tdo = 1'b0;
    #12;
    chk_abort("reset");
    trst = 1'b1;

    step(1'b0, 1'b0);
    chk("rti_tap_reset", tap_reset, 0);
    read_dr(32, 32'h0, d);
    chk("idcode", d, 32'h1000_0CFD);

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("ir_tdo0", tdo, 1);
    chk("ir_tdo_en", tdo_en, 1);
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b1);
      chk("ir_tdo_n", tdo, 0);
    end
    step(1'b1, 1'b1);
    chk("ir_exit_tdo_en", tdo_en, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("byp_extest", bsr.extest, 0);

    read_dr(5, 32'hD, d);
    chk("bypass", d[4:0], 5'b11010);

    load_ir(4'b0000);
    chk("ext_extest", bsr.extest, 1);
    step(1'b1, 1'b0);
    chk("ext_sel_cap", bsr.bsr_capture, 0);
    step(1'b0, 1'b0);
    chk("ext_cap", bsr.bsr_capture, 1);
    chk("ext_cap_shift", bsr.bsr_shift, 0);
    bsr.bsr_tdo = 1'b1;
    step(1'b0, 1'b0);
    chk("ext_sh1", bsr.bsr_shift, 1);
    chk("ext_sh1_cap", bsr.bsr_capture, 0);
    chk("ext_tdo1", tdo, 1);
    bsr.bsr_tdo = 1'b0;
    step(1'b0, 1'b0);
    chk("ext_sh2", bsr.bsr_shift, 1);
    chk("ext_tdo2", tdo, 0);
    bsr.bsr_tdo = 1'b1;
    step(1'b0, 1'b0);
    chk("ext_sh3", bsr.bsr_shift, 1);
    chk("ext_tdo3", tdo, 1);
    step(1'b1, 1'b0);
    chk("ext_ex1_shift", bsr.bsr_shift, 0);
    chk("ext_ex1_upd", bsr.bsr_update, 0);
    chk("ext_ex1_tdo", tdo, 0);
    step(1'b1, 1'b0);
    chk("ext_upd", bsr.bsr_update, 1);
    step(1'b0, 1'b0);
    chk("ext_rti_upd", bsr.bsr_update, 0);

    for (int i = 0; i < 12; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("tlr_tap_reset", tap_reset, 1);
    chk("tlr_tdo_en", tdo_en, 0);
    chk("tlr_extest", bsr.extest, 0);
    step(1'b0, 1'b0);
    read_dr(32, 32'h0, d);
    chk("tlr_idcode", d, 32'h1000_0CFD);

    load_ir(4'b0000);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("dr_abort_pre_shift", bsr.bsr_shift, 1);
    chk("dr_abort_pre_en", tdo_en, 1);
    #1 trst = 1'b0;
    #1;
    chk_abort("dr_abort");
    tms = 1'b1;
    trst = 1'b1;
    step(1'b0, 1'b0);

    load_ir(4'b0000);
    chk("ir_abort_pre_ext", bsr.extest, 1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("ir_abort_pre_en", tdo_en, 1);
    #1 trst = 1'b0;
    #1;
    chk_abort("ir_abort");
    tms = 1'b1;
    trst = 1'b1;
    step(1'b0, 1'b0);
    read_dr(32, 32'h0, d);
    chk("abort_idcode", d, 32'h1000_0CFD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
